// File: rtl/pixel_scheduler_pkg.sv
// Shared types and fixed-point helpers for the pixel scheduler and its raster counter.
package pixel_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_t;

  // Callers truncate the 64-bit result to their fixed-point word width.
  function automatic logic [63:0] fp_from_count(input logic [31:0]   cnt,
                                                input int unsigned   frac,
                                                input logic          center);
    logic [63:0] r;
    r = {32'd0, cnt} << frac;
    if (center && (frac > 0)) begin
      r = r | (64'd1 << (frac - 1));
    end
    return r;
  endfunction

  function automatic int unsigned vec3_width(input int unsigned fp_bits);
    return 3 * fp_bits;
  endfunction

endpackage

// File: rtl/pixel_scheduler_raster_counter.sv
// Raster-order h/v counters with clear, advance-on-transfer, wrap and a registered last flag.
module raster_counter
  import pixel_scheduler_pkg::*;
#(
  parameter int unsigned W      = 640,
  parameter int unsigned H      = 480,
  parameter int unsigned H_BITS = 10,
  parameter int unsigned V_BITS = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_advance,
  output logic [H_BITS-1:0] o_h,
  output logic [V_BITS-1:0] o_v,
  output logic              o_last,
  output logic [H_BITS-1:0] o_h_nxt,
  output logic [V_BITS-1:0] o_v_nxt
);

  localparam logic [H_BITS-1:0] H_MAX = H_BITS'(W - 1);
  localparam logic [V_BITS-1:0] V_MAX = V_BITS'(H - 1);

  logic [H_BITS-1:0] r_h;
  logic [V_BITS-1:0] r_v;
  logic              r_last;
  logic [H_BITS-1:0] w_h_nxt;
  logic [V_BITS-1:0] w_v_nxt;
  logic              w_last_nxt;

  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (i_clear) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
    end else if (i_advance) begin
      if (r_h == H_MAX) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v == V_MAX) ? '0 : r_v + 1'b1;
      end else begin
        w_h_nxt = r_h + 1'b1;
      end
    end
    w_last_nxt = (w_h_nxt == H_MAX) && (w_v_nxt == V_MAX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h    <= '0;
      r_v    <= '0;
      r_last <= 1'b0;
    end else begin
      r_h    <= w_h_nxt;
      r_v    <= w_v_nxt;
      r_last <= w_last_nxt;
    end
  end

  assign o_h     = r_h;
  assign o_v     = r_v;
  assign o_last  = r_last;
  assign o_h_nxt = w_h_nxt;
  assign o_v_nxt = w_v_nxt;

endmodule

// File: rtl/pixel_scheduler.sv
// Frame-level pixel source: walks a W x H frame in raster order on a valid/ready interface,
// latching the camera forward vector once per frame.
module pixel_scheduler
  import pixel_scheduler_pkg::*;
#(
  parameter int unsigned DISPLAY_WIDTH  = 640,
  parameter int unsigned DISPLAY_HEIGHT = 480,
  parameter int unsigned H_BITS         = 10,
  parameter int unsigned V_BITS         = 10,
  parameter int unsigned FP_BITS        = 24,
  parameter int unsigned FP_FRAC        = 12,
  parameter int unsigned PIX_CENTER     = 1,
  parameter int unsigned FC_BITS        = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic                 continuous_in,
  input  logic [3*FP_BITS-1:0] cam_forward_in,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [H_BITS-1:0]    hcount_out,
  output logic [V_BITS-1:0]    vcount_out,
  output logic [FP_BITS-1:0]   hcount_fp_out,
  output logic [FP_BITS-1:0]   vcount_fp_out,
  output logic [3*FP_BITS-1:0] cam_forward_out,
  output logic                 last_out,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic [FC_BITS-1:0]   frame_count_out
);

  localparam int unsigned CAM_W = vec3_width(FP_BITS);
  localparam int unsigned MAX_CNT_BITS = (H_BITS > V_BITS) ? H_BITS : V_BITS;

  if (MAX_CNT_BITS + FP_FRAC >= FP_BITS) begin : g_fp_width_check
    $error("pixel_scheduler: fixed-point word too narrow for counters plus fraction");
  end

  sched_state_t       r_state, w_state_nxt;
  logic               r_valid, w_valid_nxt;
  logic [CAM_W-1:0]   r_cam;
  logic [FP_BITS-1:0] r_hfp, r_vfp;
  logic               r_done;
  logic [FC_BITS-1:0] r_frame_cnt;

  logic               w_xfer;
  logic               w_load;
  logic               w_advance;
  logic               w_cam_latch;
  logic               w_frame_end;
  logic [H_BITS-1:0]  w_h, w_h_nxt;
  logic [V_BITS-1:0]  w_v, w_v_nxt;
  logic               w_last;

  assign w_xfer = r_valid && ready_in;

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_cam_latch = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          w_state_nxt = ST_RUN;
          w_valid_nxt = 1'b1;
          w_load      = 1'b1;
          w_cam_latch = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_xfer) begin
          if (w_last) begin
            // Frame end rewinds the raster; continuous mode keeps valid high for a bubble-free restart.
            w_frame_end = 1'b1;
            w_load      = 1'b1;
            if (continuous_in) begin
              w_cam_latch = 1'b1;
            end else begin
              w_valid_nxt = 1'b0;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  raster_counter #(
    .W      (DISPLAY_WIDTH),
    .H      (DISPLAY_HEIGHT),
    .H_BITS (H_BITS),
    .V_BITS (V_BITS)
  ) u_raster (
    .i_clk     (clk_in),
    .i_rst_n   (rst_n_in),
    .i_clear   (w_load),
    .i_advance (w_advance),
    .o_h       (w_h),
    .o_v       (w_v),
    .o_last    (w_last),
    .o_h_nxt   (w_h_nxt),
    .o_v_nxt   (w_v_nxt)
  );

  // fp coords follow the counters only when they move, so the reset value stays unoffset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid     <= 1'b0;
      r_cam       <= '0;
      r_hfp       <= '0;
      r_vfp       <= '0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_done  <= w_frame_end;
      if (w_cam_latch) begin
        r_cam <= cam_forward_in;
      end
      if (w_load || w_advance) begin
        r_hfp <= FP_BITS'(fp_from_count(32'(w_h_nxt), FP_FRAC, PIX_CENTER != 0));
        r_vfp <= FP_BITS'(fp_from_count(32'(w_v_nxt), FP_FRAC, PIX_CENTER != 0));
      end
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign valid_out       = r_valid;
  assign hcount_out      = w_h;
  assign vcount_out      = w_v;
  assign hcount_fp_out   = r_hfp;
  assign vcount_fp_out   = r_vfp;
  assign cam_forward_out = r_cam;
  assign last_out        = w_last;
  assign busy_out        = (r_state != ST_IDLE);
  assign frame_done_out  = r_done;
  assign frame_count_out = r_frame_cnt;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler on a 4x3 frame with 12-bit fraction and pixel-centre offset.
module tb_pixel_scheduler;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned NB = W * H;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic        continuous_in = 1'b0;
  logic [71:0] cam_forward_in = '0;
  logic        ready_in = 1'b0;
  logic        valid_out;
  logic [9:0]  hcount_out;
  logic [9:0]  vcount_out;
  logic [23:0] hcount_fp_out;
  logic [23:0] vcount_fp_out;
  logic [71:0] cam_forward_out;
  logic        last_out;
  logic        busy_out;
  logic        frame_done_out;
  logic [15:0] frame_count_out;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [71:0] CAM_A = 72'h000100_000200_FFF000;
  localparam logic [71:0] CAM_B = 72'h123456_ABCDEF_000FFF;
  localparam logic [71:0] CAM_C = 72'h7FFFFF_800000_001000;
  localparam logic [71:0] CAM_D = 72'h00000A_00000B_00000C;

  pixel_scheduler #(
    .DISPLAY_WIDTH  (W),
    .DISPLAY_HEIGHT (H),
    .H_BITS         (10),
    .V_BITS         (10),
    .FP_BITS        (24),
    .FP_FRAC        (12),
    .PIX_CENTER     (1),
    .FC_BITS        (16)
  ) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .start_in        (start_in),
    .continuous_in   (continuous_in),
    .cam_forward_in  (cam_forward_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .hcount_fp_out   (hcount_fp_out),
    .vcount_fp_out   (vcount_fp_out),
    .cam_forward_out (cam_forward_out),
    .last_out        (last_out),
    .busy_out        (busy_out),
    .frame_done_out  (frame_done_out),
    .frame_count_out (frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Called at a negedge where beat (0,0) is already presented; returns at the negedge after the last transfer.
  task automatic run_frame(input bit rnd, input logic [71:0] cam_exp, input int chg_at,
                           input logic [71:0] cam_new, input int start_at, output int cycles);
    int  k;
    bit  fin;
    int  eh, ev;
    k = 0; fin = 0; cycles = 0;
    while (!fin && cycles < 400) begin
      ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_in = (k == start_at);
      if (k == chg_at) cam_forward_in = cam_new;
      eh = k % W;
      ev = k / W;
      check("valid", 72'(valid_out), 72'd1);
      check("busy", 72'(busy_out), 72'd1);
      check("hcount", 72'(hcount_out), 72'(eh));
      check("vcount", 72'(vcount_out), 72'(ev));
      check("last", 72'(last_out), 72'(k == NB - 1));
      check("hfp", 72'(hcount_fp_out), 72'((eh << 12) + 'h800));
      check("vfp", 72'(vcount_fp_out), 72'((ev << 12) + 'h800));
      check("cam", cam_forward_out, cam_exp);
      if (k == NB - 1) begin
        check("hfp_last", 72'(hcount_fp_out), 72'h003800);
        check("vfp_last", 72'(vcount_fp_out), 72'h002800);
      end
      if (ready_in) k++;
      next_cycle();
      cycles++;
      if (k == NB) fin = 1;
    end
    start_in = 1'b0;
    if (!fin) check("frame_timeout", 72'(k), 72'(NB));
  endtask

  task automatic start_frame(input logic [71:0] cam);
    cam_forward_in = cam;
    start_in = 1'b1;
    next_cycle();
    start_in = 1'b0;
  endtask

  int cyc;

  initial begin
    // Reset state, including across a clock edge while held in reset
    @(negedge clk_in);
    next_cycle();
    check("rst_valid", 72'(valid_out), 72'd0);
    check("rst_h", 72'(hcount_out), 72'd0);
    check("rst_v", 72'(vcount_out), 72'd0);
    check("rst_hfp", 72'(hcount_fp_out), 72'd0);
    check("rst_vfp", 72'(vcount_fp_out), 72'd0);
    check("rst_cam", cam_forward_out, 72'd0);
    check("rst_last", 72'(last_out), 72'd0);
    check("rst_busy", 72'(busy_out), 72'd0);
    check("rst_done", 72'(frame_done_out), 72'd0);
    check("rst_count", 72'(frame_count_out), 72'd0);
    rst_n_in = 1'b1;
    next_cycle();
    check("idle_hfp", 72'(hcount_fp_out), 72'd0);
    check("idle_valid", 72'(valid_out), 72'd0);

    // Single frame, ready always high
    ready_in = 1'b1;
    start_frame(CAM_A);
    cam_forward_in = CAM_D;
    run_frame(0, CAM_A, -1, CAM_A, -1, cyc);
    check("t1_cycles", 72'(cyc), 72'(NB));
    check("t1_done", 72'(frame_done_out), 72'd1);
    check("t1_count", 72'(frame_count_out), 72'd1);
    check("t1_busy", 72'(busy_out), 72'd0);
    check("t1_valid", 72'(valid_out), 72'd0);
    next_cycle();
    check("t1_done_pulse", 72'(frame_done_out), 72'd0);

    // Random downstream stalls
    start_frame(CAM_B);
    run_frame(1, CAM_B, -1, CAM_B, -1, cyc);
    check("t2_done", 72'(frame_done_out), 72'd1);
    check("t2_count", 72'(frame_count_out), 72'd2);
    check("t2_valid", 72'(valid_out), 72'd0);

    // Continuous mode, camera changed mid-frame
    ready_in = 1'b1;
    continuous_in = 1'b1;
    start_frame(CAM_C);
    run_frame(0, CAM_C, 5, CAM_D, -1, cyc);
    check("t3_valid_nogap", 72'(valid_out), 72'd1);
    check("t3_h0", 72'(hcount_out), 72'd0);
    check("t3_v0", 72'(vcount_out), 72'd0);
    check("t3_cam_new", cam_forward_out, CAM_D);
    check("t3_done", 72'(frame_done_out), 72'd1);
    check("t3_count", 72'(frame_count_out), 72'd3);
    continuous_in = 1'b0;
    run_frame(0, CAM_D, -1, CAM_D, -1, cyc);
    check("t3_end_valid", 72'(valid_out), 72'd0);
    check("t3_end_count", 72'(frame_count_out), 72'd4);

    // Asynchronous reset at beat (2,1)
    ready_in = 1'b1;
    start_frame(CAM_A);
    for (int i = 0; i < 6; i++) next_cycle();
    check("t5_h_before", 72'(hcount_out), 72'd2);
    check("t5_v_before", 72'(vcount_out), 72'd1);
    #1;
    rst_n_in = 1'b0;
    #1;
    check("t5_valid_async", 72'(valid_out), 72'd0);
    check("t5_count_async", 72'(frame_count_out), 72'd0);
    check("t5_busy_async", 72'(busy_out), 72'd0);
    next_cycle();
    check("t5_no_done", 72'(frame_done_out), 72'd0);
    rst_n_in = 1'b1;
    next_cycle();
    check("t5_no_done2", 72'(frame_done_out), 72'd0);

    // Restart after reset, with a stray start pulse mid-frame
    start_frame(CAM_B);
    run_frame(0, CAM_B, -1, CAM_B, 4, cyc);
    check("t6_cycles", 72'(cyc), 72'(NB));
    check("t6_count", 72'(frame_count_out), 72'd1);
    check("t6_done", 72'(frame_done_out), 72'd1);
    check("t6_valid", 72'(valid_out), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
